// File: rtl/counter_prog.sv
// Parametrised up/down counter with programmable terminal, synchronous load,
// one-cycle reached pulse and sticky done flag. COUNTER_PROG_SATURATE_EN selects saturation.
module counter_prog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] terminal,
  input  logic             clear_done,
  output logic [WIDTH-1:0] val,
  output logic             reached,
  output logic             done
);

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] boundary;
  logic [WIDTH-1:0] val_nx;
  logic             reached_nx;
  logic             done_nx;

  // Candidate value for a step in the current direction, including boundary handling
  always_comb begin
    step_val = val;
    boundary = up ? terminal : '0;
    if (up) begin
      if (val < terminal) begin
        step_val = val + WIDTH'(1);
      end else begin
`ifdef COUNTER_PROG_SATURATE_EN
        step_val = val;
`else
        step_val = '0;
`endif
      end
    end else begin
      if (val != '0) begin
        step_val = val - WIDTH'(1);
      end else begin
`ifdef COUNTER_PROG_SATURATE_EN
        step_val = val;
`else
        step_val = terminal;
`endif
      end
    end
  end

  // Load beats enable; a reached set beats clear_done
  always_comb begin
    val_nx     = val;
    reached_nx = 1'b0;
    done_nx    = done & ~clear_done;
    if (load) begin
      val_nx  = load_val;
      done_nx = 1'b0;
    end else if (en) begin
      val_nx     = step_val;
      reached_nx = (step_val == boundary) && (step_val != val);
      if (reached_nx) begin
        done_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val     <= '0;
      reached <= 1'b0;
      done    <= 1'b0;
    end else begin
      val     <= val_nx;
      reached <= reached_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// Directed bench for counter_prog: reference model pushes expectations to a queue,
// popped and checked one clock later. Honours COUNTER_PROG_SATURATE_EN.
module tb_counter_prog;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] terminal;
  logic         clear_done;
  logic [W-1:0] val;
  logic         reached;
  logic         done;

  typedef struct {
    logic [W-1:0] v;
    logic         r;
    logic         d;
  } exp_t;

  exp_t exp_q[$];

  int m_val;
  bit m_r;
  bit m_d;
  int total;
  int passed;

  counter_prog #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .terminal  (terminal),
    .clear_done(clear_done),
    .val       (val),
    .reached   (reached),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  // Reference model: next state from current model state and driven inputs
  task automatic model_step();
    int nxt;
    int bnd;
    if (!rst) begin
      m_val = 0; m_r = 0; m_d = 0;
    end else if (load) begin
      m_val = int'(load_val); m_r = 0; m_d = 0;
    end else if (en) begin
      bnd = up ? int'(terminal) : 0;
      if (up) begin
`ifdef COUNTER_PROG_SATURATE_EN
        nxt = (m_val >= int'(terminal)) ? m_val : m_val + 1;
`else
        nxt = (m_val >= int'(terminal)) ? 0 : m_val + 1;
`endif
      end else begin
`ifdef COUNTER_PROG_SATURATE_EN
        nxt = (m_val == 0) ? 0 : m_val - 1;
`else
        nxt = (m_val == 0) ? int'(terminal) : m_val - 1;
`endif
      end
      m_r   = (nxt == bnd) && (nxt != m_val);
      m_d   = m_r || (m_d && !clear_done);
      m_val = nxt;
    end else begin
      m_r = 0;
      m_d = m_d && !clear_done;
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    model_step();
    e.v = W'(m_val);
    e.r = m_r;
    e.d = m_d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".val"}, val, e.v);
    check({tag, ".reached"}, W'(reached), W'(e.r));
    check({tag, ".done"}, W'(done), W'(e.d));
  endtask

  task automatic set_in(input logic e_i, input logic u_i, input logic l_i,
                        input logic [W-1:0] lv_i, input logic [W-1:0] t_i, input logic c_i);
    en = e_i; up = u_i; load = l_i; load_val = lv_i; terminal = t_i; clear_done = c_i;
  endtask

  initial begin
    total = 0; passed = 0;
    m_val = 0; m_r = 0; m_d = 0;
    rst = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, '0, 8'd25, 1'b0);
    #2;
    check("async_reset.val", val, '0);
    tick("reset");
    tick("reset");

    // Basic up wrap at terminal 25
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd25, 1'b0);
    for (int i = 0; i < 30; i++) tick("up_wrap");

    // Hold with enable low
    en = 1'b0;
    tick("hold");

    // Down wrap from 3 with terminal 10
    set_in(1'b0, 1'b0, 1'b1, 8'd3, 8'd10, 1'b0);
    tick("load3");
    set_in(1'b1, 1'b0, 1'b0, '0, 8'd10, 1'b0);
    for (int i = 0; i < 6; i++) tick("down_wrap");

    // Load beats enable and clears done
    set_in(1'b1, 1'b1, 1'b1, 8'h7F, 8'd10, 1'b1);
    tick("load_prio");

    // clear_done coincident with a reached set: set wins
    set_in(1'b0, 1'b1, 1'b1, 8'd8, 8'd10, 1'b0);
    tick("load8");
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd10, 1'b0);
    tick("to9");
    clear_done = 1'b1;
    tick("clear_vs_set");
    en = 1'b0;
    tick("clear_alone");
    clear_done = 1'b0;

    // Mid-count asynchronous reset at val 17
    set_in(1'b0, 1'b1, 1'b1, 8'd10, 8'd25, 1'b0);
    tick("load10");
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd25, 1'b0);
    for (int i = 0; i < 7; i++) tick("to17");
    check("pre_reset.val", val, 8'd17);
    #2;
    rst = 1'b0;
    #1;
    m_val = 0; m_r = 0; m_d = 0;
    check("mid_reset.val", val, W'(m_val));
    check("mid_reset.reached", W'(reached), W'(m_r));
    check("mid_reset.done", W'(done), W'(m_d));
    @(negedge clk);
    rst = 1'b1;
    tick("resume");
    tick("resume");

    // Terminal lowered below val: rollover without reached, later arrival at 5
    set_in(1'b0, 1'b1, 1'b1, 8'd20, 8'd25, 1'b0);
    tick("load20");
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd5, 1'b0);
    for (int i = 0; i < 7; i++) tick("term_low");

    // Direction change mid-count
    set_in(1'b1, 1'b0, 1'b0, '0, 8'd5, 1'b0);
    tick("dir_down");
    up = 1'b1;
    tick("dir_up");

    // Terminal zero: stays at 0, never reaches
    set_in(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0);
    tick("load0");
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick("term_zero");

    // Approach terminal from below and past it (wrap or saturate by build)
    set_in(1'b0, 1'b1, 1'b1, 8'd22, 8'd25, 1'b0);
    tick("load22");
    set_in(1'b1, 1'b1, 1'b0, '0, 8'd25, 1'b0);
    for (int i = 0; i < 6; i++) tick("at_top");

    // Down from 0 (wrap to terminal or hold by build)
    set_in(1'b0, 1'b0, 1'b1, 8'd1, 8'd25, 1'b0);
    tick("load1");
    set_in(1'b1, 1'b0, 1'b0, '0, 8'd25, 1'b0);
    for (int i = 0; i < 4; i++) tick("at_bottom");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_prog.md
# counter_prog

Parametrised up/down counter with a run-time programmable terminal value, synchronous load, a one-cycle `reached` pulse and a sticky `done` flag. It is the general-purpose successor to the fixed 8-bit enable counter. It sits beside timing and sequencing logic as the standard event and interval counter. Clock is `clk`; reset `rst` is asynchronous and active-low.

## Interface
- `WIDTH`, default 8: counter, terminal and load width in bits (≥2).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset (asserted at 0).
- `en`  in  1: count enable; one step per clock while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `load`  in  1: synchronous load of `load_val`.
- `load_val`  in  WIDTH: value loaded when `load` = 1.
- `terminal`  in  WIDTH: programmable terminal count; sampled every cycle.
- `clear_done`  in  1: synchronous clear of `done`.
- `val`  out  WIDTH: current count, registered.
- `reached`  out  1: one-cycle pulse, registered.
- `done`  out  1: sticky flag, registered.

## Operation
- Priority per clock is `load` > `en` > hold.
- **Load:** `val` ← `load_val`, `reached` ← 0, `done` ← 0. `en` and `clear_done` are ignored that cycle.
- **Boundary value:** `terminal` when counting up; 0 when counting down.
- **Up step:**
  - if `val` < `terminal`, then `val` ← `val`+1;
  - otherwise `val` ≥ `terminal` and the step is a rollover (wrap behaviour below).
- **Down step:**
  - if `val` > 0, then `val` ← `val`−1;
  - otherwise `val` = 0 and the step is a rollover.
- **Rollover (default build):**
  - up: `val` ← 0;
  - down: `val` ← `terminal`.
- `reached` ← 1 only when a step is taken, the next `val` equals the boundary value, and the next `val` differs from the current `val`. Otherwise `reached` ← 0.
- `done` is set whenever `reached` is set.
  - `done` is cleared by `clear_done` or `load`.
  - If `clear_done` and a `reached` set occur in the same cycle, set wins and `done` stays 1.
- **Terminal changed mid-count:** no special handling. Up-counting with `val` > `terminal` rolls over on the next step, with no `reached` pulse.
- **`terminal` = 0, wrap build:** `val` stays 0 and `reached` never pulses.
- `up` may change on any cycle. The direction takes effect on the step in that same cycle.

## Timing
- Reset (`rst` = 0) immediately forces `val` = 0, `reached` = 0, `done` = 0. This holds regardless of `clk` and applies mid-count too.
- Reset release is synchronous to the next rising edge. The first step can occur on the first edge with `rst` = 1.
- Latency is one clock: `en`, `up`, `load`, `terminal` and `clear_done` are sampled at the rising edge, and `val`, `reached` and `done` update on that same edge.
- `reached` is high for exactly one clock per arrival. It is never high two consecutive cycles unless `val` leaves and re-arrives at the boundary, which is impossible for `WIDTH` ≥ 2 and `terminal` ≥ 2.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `COUNTER_PROG_SATURATE_EN`.
- **Defined:** the counter saturates instead of rolling over.
  - Up with `val` ≥ `terminal`: `val` holds.
  - Down with `val` = 0: `val` holds.
  - No `reached` pulse occurs while holding. `reached` still pulses once on arrival at the boundary.
- **Undefined:** rollover behaviour as in Operation.

## Test plan
- **Basic up wrap** (default build, `WIDTH`=8, `terminal`=25):
  - Stimulus: `rst` low 2 cycles, then `en`=1, `up`=1 for 30 cycles.
  - Required: `val` runs 0..25, then 0..3; `reached` is high only in the cycle `val`=25; `done`=1 from then on.
- **Down wrap:**
  - Stimulus: load 3, `terminal`=10, `up`=0, `en`=1 for 6 cycles.
  - Required: `val` = 2, 1, 0, 10, 9, 8; `reached` is high only when `val`=0.
- **Load and clear priority:**
  - Stimulus: assert `load`=1 with `load_val`=0x7F and `en`=1 in the same cycle.
  - Required: `val`=0x7F, `done`=0.
  - Stimulus: `clear_done` in the same cycle as a `reached` set.
  - Required: `done` stays 1.
- **Mid-count reset:**
  - Stimulus: drive `rst`=0 asynchronously between edges while `val`=17.
  - Required: `val`=0, `reached`=0, `done`=0 before the next edge.
  - Required: counting resumes from 0 on the first edge after release.
- **Terminal lowered below `val`:**
  - Stimulus: `val`=20, `terminal` changed to 5, `up`=1, `en`=1.
  - Required: next `val`=0 with no `reached` pulse; later `reached` pulses at `val`=5.
- **Saturate build** (`COUNTER_PROG_SATURATE_EN` defined, `terminal`=25):
  - Stimulus: count up.
  - Required: `val` stops at 25 with `reached` pulsing once.
  - Stimulus: count down.
  - Required: `val` holds at 0.
